// File: rtl/draw_mine_field_pkg.sv
// Shared definitions for the mine-field overlay: default overlay colours,
// the board index type and the level -> board dimension table.
// Pure package: no ports, no state.
package draw_mine_field_pkg;

  // Colour defaults (12-bit RGB, 4 bits per channel).
  localparam logic [11:0] MINE_RGB_DEF = 12'h000;
  localparam logic [11:0] TRIG_RGB_DEF = 12'hF00;

  // Board indices are 1-based cell coordinates.
  localparam int BOARD_IDX_W = 5;
  typedef logic [BOARD_IDX_W-1:0] board_idx_t;

  // Cells per side for each difficulty level; level 0 means no board.
  function automatic logic [7:0] dim_of_level(input logic [1:0] level);
    case (level)
      2'd1:    return 8'd8;
      2'd2:    return 8'd12;
      2'd3:    return 8'd16;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/draw_mine_field_if.sv
// VGA pixel stream bundle: timing counters, sync/blank strobes and colour.
// Modport in: the consumer side (all signals are inputs).
// Modport out: the producer side (all signals are outputs).
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_mine_field_cell_tracker.sv
// Tracks which board cell and which pixel offset inside it the current pixel is in.
// Latency: 1 clk (outputs align with a 1-cycle delayed copy of hcount/vcount); no backpressure.
// Ports: clk/rst; hcount/vcount pixel position; board_xpos/ypos and button_size geometry;
//        col/row 0-based cell (saturating), xoff/yoff offset within the cell.
module cell_tracker #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      hcount,
  input  logic [10:0]      vcount,
  input  logic [10:0]      board_xpos,
  input  logic [10:0]      board_ypos,
  input  logic [6:0]       button_size,
  output logic [IDX_W-1:0] col,
  output logic [IDX_W-1:0] row,
  output logic [6:0]       xoff,
  output logic [6:0]       yoff
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  // Counting instead of dividing by the pitch. col/row saturate so they can
  // never wrap back into the board area past its right/bottom edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col  <= '0;
      row  <= '0;
      xoff <= '0;
      yoff <= '0;
    end else begin
      if (hcount == board_xpos) begin
        col  <= '0;
        xoff <= '0;
      end else if (xoff >= button_size) begin
        xoff <= '0;
        if (col != IDX_MAX) col <= col + IDX_ONE;
      end else begin
        xoff <= xoff + 7'd1;
      end

      // Vertical position steps once per line, on the first pixel.
      if (hcount == 11'd0) begin
        if (vcount == board_ypos) begin
          row  <= '0;
          yoff <= '0;
        end else if (vcount > board_ypos) begin
          if (yoff >= button_size) begin
            yoff <= '0;
            if (row != IDX_MAX) row <= row + IDX_ONE;
          end else begin
            yoff <= yoff + 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/draw_mine_field.sv
// Mine-field overlay: stores a mine bitmap and, while explode is high, draws an X on
// every mine and highlights the triggering cell. Latency: 2 clk in -> out for all fields.
// No backpressure: one pixel per clock in, one out.
// Ports: clk, rst (async active-low); level/button_size/board_xpos/board_ypos geometry;
//        mine_we/mine_ind_x/mine_ind_y/clear load side; explode/trig_ind_x/trig_ind_y;
//        mine_count/load_err status; in/out VGA stream.
module draw_mine_field
  import draw_mine_field_pkg::*;
#(
  parameter int          MAX_DIM  = 16,
  parameter int          IDX_W    = 5,
  parameter int          MARGIN   = 8,
  parameter int          STROKE   = 6,
  parameter logic [11:0] MINE_RGB = MINE_RGB_DEF,
  parameter logic [11:0] TRIG_RGB = TRIG_RGB_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       level,
  input  logic [6:0]       button_size,
  input  logic [10:0]      board_xpos,
  input  logic [10:0]      board_ypos,
  input  logic             mine_we,
  input  logic [IDX_W-1:0] mine_ind_x,
  input  logic [IDX_W-1:0] mine_ind_y,
  input  logic             clear,
  input  logic             explode,
  input  logic [IDX_W-1:0] trig_ind_x,
  input  logic [IDX_W-1:0] trig_ind_y,
  output logic [8:0]       mine_count,
  output logic             load_err,
  vga_if.in                in,
  vga_if.out               out
);

  localparam int                 CW       = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [8:0]         MAX_CNT  = 9'(MAX_DIM * MAX_DIM);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic signed [8:0]  MARGIN_S = 9'(MARGIN);
  localparam logic signed [8:0]  STROKE_S = 9'(STROKE);

  logic [7:0] dim;
  assign dim = dim_of_level(level);

  // ---------------- mine bitmap load ----------------
  logic [MAX_DIM-1:0][MAX_DIM-1:0] bitmap;   // [row][col]
  logic [IDX_W-1:0] wr_x, wr_y;
  logic             wr_ok;

  assign wr_x  = mine_ind_x - IDX_ONE;
  assign wr_y  = mine_ind_y - IDX_ONE;
  // dim is 0 for level 0, so that case falls out of the range test as well.
  assign wr_ok = (mine_ind_x != '0) && (8'(mine_ind_x) <= dim) &&
                 (mine_ind_y != '0) && (8'(mine_ind_y) <= dim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitmap     <= '0;
      mine_count <= '0;
      load_err   <= 1'b0;
    end else if (clear) begin
      bitmap     <= '0;
      mine_count <= '0;
      load_err   <= 1'b0;
    end else if (mine_we) begin
      if (wr_ok) begin
        bitmap[wr_y[CW-1:0]][wr_x[CW-1:0]] <= 1'b1;
        // Only a new mine bumps the count; rewrites are idempotent.
        if (!bitmap[wr_y[CW-1:0]][wr_x[CW-1:0]] && (mine_count != MAX_CNT))
          mine_count <= mine_count + 9'd1;
      end else begin
        load_err <= 1'b1;
      end
    end
  end

  // ---------------- trigger capture ----------------
  logic             explode_q;
  logic             trig_valid;
  logic [IDX_W-1:0] trig_x, trig_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      explode_q  <= 1'b0;
      trig_valid <= 1'b0;
      trig_x     <= '0;
      trig_y     <= '0;
    end else begin
      explode_q <= explode;
      if (clear) begin
        trig_valid <= 1'b0;
      end else if (explode && !explode_q) begin
        trig_valid <= 1'b1;
        trig_x     <= trig_ind_x;
        trig_y     <= trig_ind_y;
      end else if (!explode && explode_q) begin
        trig_valid <= 1'b0;
      end
    end
  end

  // ---------------- stage 1: delay stream, track cell ----------------
  logic [10:0]      hc1, vc1;
  logic             hs1, vs1, hb1, vb1;
  logic [11:0]      rgb1;
  logic [IDX_W-1:0] col, row;
  logic [6:0]       xoff, yoff;

  cell_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .hcount      (in.hcount),
    .vcount      (in.vcount),
    .board_xpos  (board_xpos),
    .board_ypos  (board_ypos),
    .button_size (button_size),
    .col         (col),
    .row         (row),
    .xoff        (xoff),
    .yoff        (yoff)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc1  <= '0;
      vc1  <= '0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      hb1  <= 1'b0;
      vb1  <= 1'b0;
      rgb1 <= '0;
    end else begin
      hc1  <= in.hcount;
      vc1  <= in.vcount;
      hs1  <= in.hsync;
      vs1  <= in.vsync;
      hb1  <= in.hblnk;
      vb1  <= in.vblnk;
      rgb1 <= in.rgb;
    end
  end

  // ---------------- stage 2: glyph test and colour select ----------------
  logic signed [8:0] sx, sy, sb, d1, d2, ad1, ad2;
  logic              glyph_hit, in_board, mine_bit, is_trig;
  logic [11:0]       pix_rgb;

  always_comb begin
    sx  = $signed({2'b00, xoff});
    sy  = $signed({2'b00, yoff});
    sb  = $signed({2'b00, button_size});
    d1  = sx - sy;               // main diagonal distance
    d2  = sx + sy - sb;          // anti-diagonal distance
    ad1 = d1[8] ? -d1 : d1;
    ad2 = d2[8] ? -d2 : d2;
    glyph_hit = (sx >= MARGIN_S) && (sx <= sb - MARGIN_S) &&
                (sy >= MARGIN_S) && (sy <= sb - MARGIN_S) &&
                ((ad1 < STROKE_S) || (ad2 < STROKE_S));
  end

  assign in_board = (hc1 >= board_xpos) && (vc1 >= board_ypos) &&
                    (8'(col) < dim) && (8'(row) < dim);
  assign mine_bit = in_board && bitmap[row[CW-1:0]][col[CW-1:0]];
  assign is_trig  = trig_valid && (col == trig_x - IDX_ONE) && (row == trig_y - IDX_ONE);

  always_comb begin
    pix_rgb = rgb1;
    if (explode && (level != 2'd0) && in_board) begin
      if (mine_bit && glyph_hit) pix_rgb = MINE_RGB;
      else if (is_trig)          pix_rgb = TRIG_RGB;
    end
  end

  logic [10:0] hc2, vc2;
  logic        hs2, vs2, hb2, vb2;
  logic [11:0] rgb2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc2  <= '0;
      vc2  <= '0;
      hs2  <= 1'b0;
      vs2  <= 1'b0;
      hb2  <= 1'b0;
      vb2  <= 1'b0;
      rgb2 <= '0;
    end else begin
      hc2  <= hc1;
      vc2  <= vc1;
      hs2  <= hs1;
      vs2  <= vs1;
      hb2  <= hb1;
      vb2  <= vb1;
      rgb2 <= pix_rgb;
    end
  end

  assign out.hcount = hc2;
  assign out.vcount = vc2;
  assign out.hsync  = hs2;
  assign out.vsync  = vs2;
  assign out.hblnk  = hb2;
  assign out.vblnk  = vb2;
  assign out.rgb    = rgb2;

endmodule

// File: tb/tb_draw_mine_field.sv
// Bench for draw_mine_field: directed steps plus randomized pixels and geometry,
// checked against an arithmetic model of the board (division/modulo on pixel
// coordinates, a 2-D mine array) and a 2-deep delay for the stream fields.
module tb_draw_mine_field;

  localparam int M_MARGIN = 8;
  localparam int M_STROKE = 6;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  level;
  logic [6:0]  button_size;
  logic [10:0] bx, by;
  logic        mine_we;
  logic [4:0]  mine_ind_x, mine_ind_y;
  logic        clear;
  logic        explode;
  logic [4:0]  trig_ind_x, trig_ind_y;
  logic [8:0]  mine_count;
  logic        load_err;

  vga_if vin();
  vga_if vout();

  draw_mine_field dut (
    .clk         (clk),
    .rst         (rst),
    .level       (level),
    .button_size (button_size),
    .board_xpos  (bx),
    .board_ypos  (by),
    .mine_we     (mine_we),
    .mine_ind_x  (mine_ind_x),
    .mine_ind_y  (mine_ind_y),
    .clear       (clear),
    .explode     (explode),
    .trig_ind_x  (trig_ind_x),
    .trig_ind_y  (trig_ind_y),
    .mine_count  (mine_count),
    .load_err    (load_err),
    .in          (vin),
    .out         (vout)
  );

  always #5 clk = ~clk;

  // ---------------- reference state ----------------
  bit   bm [16][16];          // [row][col], 0-based
  bit   m_err, m_tv;
  int   m_tx, m_ty;
  int   n_chk = 0, n_pass = 0, n_fail = 0;
  pix_t exp_q[$];
  bit   chk_q[$];

  function automatic int lvl_dim(input logic [1:0] l);
    case (l)
      2'd1: return 8;
      2'd2: return 12;
      2'd3: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        n += int'(bm[r][c]);
    return n;
  endfunction

  function automatic logic [11:0] model_rgb(input int h, input int v, input logic [11:0] rgb);
    int d, b, p, c, r, xo, yo;
    bit g;
    d = lvl_dim(level);
    b = int'(button_size);
    p = b + 1;
    if (!explode || d == 0) return rgb;
    if (h < int'(bx) || v < int'(by)) return rgb;
    c  = (h - int'(bx)) / p;
    xo = (h - int'(bx)) % p;
    r  = (v - int'(by)) / p;
    yo = (v - int'(by)) % p;
    if (c >= d || r >= d) return rgb;
    g = (xo >= M_MARGIN) && (xo <= b - M_MARGIN) && (yo >= M_MARGIN) && (yo <= b - M_MARGIN) &&
        ((iabs(xo - yo) < M_STROKE) || (iabs(xo + yo - b) < M_STROKE));
    if (bm[r][c] && g) return 12'h000;
    if (m_tv && c == m_tx - 1 && r == m_ty - 1) return 12'hF00;
    return rgb;
  endfunction

  function automatic pix_t out_pix();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Junk pixel, pipeline advance, and forget anything not yet compared.
  task automatic idle(input int n);
    vin.hcount = 11'h7FF;
    vin.vcount = 11'h7FF;
    repeat (n) tick();
    exp_q.delete();
    chk_q.delete();
  endtask

  // ovr: -1 = model colour, -2 = input colour, >= 0 = that constant colour.
  task automatic step(input int h, input int v, input int ovr, input bit chk);
    pix_t p, e;
    p.hc  = 11'(h);
    p.vc  = 11'(v);
    {p.hs, p.vs, p.hb, p.vb} = 4'($urandom);
    p.rgb = 12'($urandom);
    vin.hcount = p.hc;  vin.vcount = p.vc;
    vin.hsync  = p.hs;  vin.vsync  = p.vs;
    vin.hblnk  = p.hb;  vin.vblnk  = p.vb;
    vin.rgb    = p.rgb;
    e = p;
    if (ovr >= 0)       e.rgb = 12'(ovr);
    else if (ovr == -1) e.rgb = model_rgb(h, v, p.rgb);
    exp_q.push_back(e);
    chk_q.push_back(chk);
    tick();
    if (exp_q.size() >= 2) begin
      if (chk_q[0])
        check($sformatf("pix@%0d,%0d", exp_q[0].hc, exp_q[0].vc), 64'(out_pix()), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      void'(chk_q.pop_front());
    end
  endtask

  task automatic drain();
    step(2047, 2047, -1, 1'b0);
    idle(2);
  endtask

  // Walk lines from the board top to v_t, then pixels from the board left to h_t.
  task automatic line_to(input int v_t, input int h_t, input int ovr);
    for (int v = int'(by); v <= v_t; v++) step(0, v, -1, 1'b1);
    for (int h = int'(bx); h < h_t; h++) step(h, v_t, -1, 1'b1);
    step(h_t, v_t, ovr, 1'b1);
    drain();
  endtask

  // Walk lines from the board top; on the listed lines sweep the full board width.
  task automatic scan(input int l0, input int l1, input int l2);
    int vmax, w;
    vmax = (l0 > l1) ? l0 : l1;
    vmax = (vmax > l2) ? vmax : l2;
    w = lvl_dim(level) * (int'(button_size) + 1);
    for (int v = int'(by); v <= vmax; v++) begin
      step(0, v, -1, 1'b1);
      if (v == l0 || v == l1 || v == l2)
        for (int h = int'(bx); h < int'(bx) + w + 4; h++) step(h, v, -1, 1'b1);
    end
    drain();
  endtask

  task automatic load(input int x, input int y, input bit clr);
    int d;
    mine_we = 1'b1;  mine_ind_x = 5'(x);  mine_ind_y = 5'(y);  clear = clr;
    tick();
    mine_we = 1'b0;  clear = 1'b0;
    d = lvl_dim(level);
    if (clr) begin
      foreach (bm[r, c]) bm[r][c] = 1'b0;
      m_err = 1'b0;
      m_tv  = 1'b0;
    end else if (x >= 1 && x <= d && y >= 1 && y <= d) begin
      bm[y-1][x-1] = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 64'(mine_count), 64'(m_count()));
    check({tag, "_err"},   64'(load_err),   64'(m_err));
  endtask

  // Drop explode for at least one cycle, then raise it with a new trigger cell.
  task automatic pulse_trig(input int tx, input int ty);
    explode = 1'b0;
    tick();
    m_tv = 1'b0;
    trig_ind_x = 5'(tx);  trig_ind_y = 5'(ty);
    explode = 1'b1;
    tick();
    m_tv = 1'b1;  m_tx = tx;  m_ty = ty;
    idle(2);
  endtask

  initial begin
    int d, w, lx, ly, tx, ty;
    rst = 1'b0;
    level = 2'd1;  button_size = 7'd20;  bx = 11'd10;  by = 11'd10;
    mine_we = 1'b0;  mine_ind_x = '0;  mine_ind_y = '0;  clear = 1'b0;
    explode = 1'b0;  trig_ind_x = '0;  trig_ind_y = '0;
    m_err = 1'b0;  m_tv = 1'b0;  m_tx = 0;  m_ty = 0;
    foreach (bm[r, c]) bm[r][c] = 1'b0;
    vin.hcount = 11'd123;  vin.vcount = 11'd45;  vin.rgb = 12'hABC;
    vin.hsync = 1'b1;  vin.vsync = 1'b1;  vin.hblnk = 1'b1;  vin.vblnk = 1'b1;
    #1;
    check("reset_out", 64'(out_pix()), 64'd0);
    check_status("reset");
    tick();
    rst = 1'b1;
    idle(2);

    // Load a mine, stream random pixels with explode low, then reset mid-frame.
    load(2, 2, 1'b0);
    check_status("pre_reset");
    for (int i = 0; i < 400; i++) step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), -1, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("async_reset_out", 64'(out_pix()), 64'd0);
    check("async_reset_count", 64'(mine_count), 64'd0);
    foreach (bm[r, c]) bm[r][c] = 1'b0;
    m_err = 1'b0;  m_tv = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Loading, duplicates, range errors, clear priority.
    load(3, 5, 1'b0);  check_status("load_3_5");
    load(3, 5, 1'b0);  check_status("dup_3_5");
    load(9, 1, 1'b0);  check_status("oob_9_1");
    load(0, 4, 1'b0);  check_status("oob_0_4");
    mine_we = 1'b1;  mine_ind_x = 5'd1;  mine_ind_y = 5'd1;
    load(1, 1, 1'b1);  check_status("clear_we");
    load(1, 1, 1'b0);  check_status("reload_1_1");
    level = 2'd0;
    load(2, 2, 1'b0);  check_status("level0_write");
    load(0, 0, 1'b1);  check_status("clear");

    // Glyph draw on a 12x12 board.
    level = 2'd2;  button_size = 7'd40;  bx = 11'd100;  by = 11'd50;
    load(2, 1, 1'b0);  check_status("load_2_1");
    pulse_trig(0, 0);
    line_to(70, 161, 12'h000);
    line_to(70, 143, -2);
    scan(70, 111, 60);

    // Triggered cell (4,4), then with a mine in it.
    pulse_trig(4, 4);
    line_to(193, 225, 12'hF00);
    scan(193, 180, 215);
    load(4, 4, 1'b0);
    line_to(193, 243, 12'h000);
    line_to(193, 225, 12'hF00);

    // Re-trigger at (1,2): old cell reverts, new one lights.
    pulse_trig(1, 2);
    line_to(193, 225, -2);
    line_to(111, 102, 12'hF00);
    scan(111, 193, 95);

    // Pass-through with explode low over the board, then with level 0.
    explode = 1'b0;  tick();  m_tv = 1'b0;  idle(2);
    line_to(70, 161, -2);
    for (int i = 0; i < 1000; i++) step(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)), -2, 1'b1);
    drain();
    pulse_trig(4, 4);
    level = 2'd0;
    idle(2);
    for (int i = 0; i < 1000; i++) step(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)), -2, 1'b1);
    drain();

    // Randomized geometry, mines and trigger.
    for (int f = 0; f < 3; f++) begin
      load(0, 0, 1'b1);
      level = 2'(f + 1);
      button_size = 7'($urandom_range(20, 40));
      bx = 11'($urandom_range(1, 100));
      by = 11'($urandom_range(0, 60));
      d = lvl_dim(level);
      for (int k = 0; k < 10; k++) begin
        lx = int'($urandom_range(0, d + 1));
        ly = int'($urandom_range(0, d + 1));
        load(lx, ly, 1'b0);
      end
      check_status("rand_load");
      tx = int'($urandom_range(1, d));
      ty = int'($urandom_range(1, d));
      pulse_trig(tx, ty);
      w = d * (int'(button_size) + 1);
      scan(int'(by) + int'($urandom_range(0, w / 3 - 1)),
           int'(by) + w / 3 + int'($urandom_range(0, w / 3 - 1)),
           int'(by) + (ty - 1) * (int'(button_size) + 1) + int'($urandom_range(0, int'(button_size))));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/draw_mine_field.md
Name: draw_mine_field

Overview:
- Parametrised successor to the single-mine overlay.
- Holds a mine bitmap for the whole board, loaded one cell per cycle.
- On explode, overlays every mine's X glyph on the VGA stream and fills the triggering cell with a highlight colour.
- Sits in the redraw chain between board drawing and the cursor/mouse overlay.

Parameters:
- MAX_DIM, 16: maximum board cells per side; bitmap is MAX_DIM*MAX_DIM bits.
- IDX_W, 5: cell index width; indices are 1-based.
- MARGIN, 8: glyph inset from the cell edge, in pixels.
- STROKE, 6: half-width of each glyph diagonal, in pixels.
- MINE_RGB, 12'h000: glyph colour.
- TRIG_RGB, 12'hF00: background colour of the triggering cell.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- level  in  2  0 = off, 1..3 select board dimension via the package table
- button_size  in  7  cell side in pixels; cell pitch = button_size+1
- board_xpos  in  11  board top-left x
- board_ypos  in  11  board top-left y
- mine_we  in  1  write the mine at mine_ind_x/y this cycle
- mine_ind_x  in  IDX_W  column, 1-based
- mine_ind_y  in  IDX_W  row, 1-based
- clear  in  1  clear bitmap and counters
- explode  in  1  level; glyphs are drawn while high
- trig_ind_x  in  IDX_W  triggering cell column, sampled on the explode rising edge
- trig_ind_y  in  IDX_W  triggering cell row, sampled on the explode rising edge
- mine_count  out  9  number of distinct mines stored
- load_err  out  1  sticky flag: an out-of-range write was rejected
- in  vga_if.in  -  upstream timing and rgb
- out  vga_if.out  -  downstream timing and rgb

Behaviour:
- Reset (rst low, asynchronous): bitmap all 0, mine_count 0, load_err 0, trigger registers 0, all pipeline registers 0, so out.* = 0.
- Load:
  - mine_we with 1 <= idx <= dim(level) on both axes sets bit [y-1][x-1].
  - mine_count increments only if that bit was previously 0.
  - An out-of-range write (or level = 0) is ignored and sets load_err.
  - clear has priority over mine_we in the same cycle: bitmap, mine_count and load_err all go to 0 next cycle.
- Trigger capture:
  - The explode rising edge (registered edge detect) latches trig_ind_x/y and sets trig_valid.
  - trig_valid clears when explode falls, on clear, or on reset.
- Pixel tracking, stage 1 (runs whether or not explode is high):
  - Horizontal: when in.hcount == board_xpos, set col = 0 and xoff = 0. Afterwards xoff increments each pixel; when xoff == button_size it wraps to 0 and col increments.
  - Vertical: at in.hcount == 0, if in.vcount == board_ypos set row = 0 and yoff = 0; if in.vcount > board_ypos advance yoff/row with the same wrap rule.
  - in_board = hcount >= board_xpos, vcount >= board_ypos, col < dim and row < dim.
  - No multipliers or dividers are used.
- Stage 2:
  - Read bitmap[row][col].
  - Compute the glyph test on signed 9-bit values:
    - MARGIN <= xoff, yoff <= button_size-MARGIN, and
    - |xoff-yoff| < STROKE, or |xoff+yoff-button_size| < STROKE.
  - is_trig = trig_valid and col == trig_x-1 and row == trig_y-1.
- Colour priority, applied only when explode, level > 0 and in_board:
  1. mine bit and glyph hit -> MINE_RGB
  2. is_trig -> TRIG_RGB
  3. otherwise the delayed in.rgb
- Latency: exactly 2 clk from in to out. All sync, blank and count fields are delayed identically.
- Board geometry inputs may change only during vblnk; mid-frame changes give undefined pixels for that frame only.
- mine_count saturates at MAX_DIM*MAX_DIM.

Decomposition:
- colour_pkg additions: MINE_RGB and TRIG_RGB defaults.
- New board_pkg:
  - typedef board_idx_t (logic [IDX_W-1:0]).
  - Function dim_of_level: level 1 -> 8, 2 -> 12, 3 -> 16.
- One sub-module, cell_tracker: the stage-1 col/row/xoff/yoff counters. Instantiate it once, with the horizontal and vertical counters inside it.

Test Plan:
- Reset then load: rst low mid-frame -> all out.* 0 within 0 cycles. After release, load (3,5) -> mine_count = 1. Load (3,5) again -> count stays 1, load_err = 0.
- Range check: level = 1, write (9,1) and (0,4) -> bitmap unchanged, load_err = 1. Then clear together with mine_we (1,1) -> count 0, err 0, bit (1,1) not set.
- Glyph draw: level = 2, button_size = 40, board at (100,50), mine at (2,1), explode high.
  - Pixel hcount = 100+41+20, vcount = 50+20 (cell centre) -> out.rgb = 12'h000 two cycles later.
  - Pixel at xoff = 2 -> out.rgb equals the input rgb.
- Triggered cell: explode rises with trig = (4,4) and no mine there -> a non-glyph pixel in cell (4,4) outputs 12'hF00. With a mine at (4,4), the glyph centre pixel stays 12'h000 (glyph wins).
- Pass-through: explode low, or level = 0 -> out equals in delayed 2 clk for a full 800x600 frame; compared cycle-by-cycle against a delay model.
- Explode toggle: drop explode for 1 cycle, then raise it with new trig = (1,2) -> the old trigger cell reverts to input rgb and the new cell is highlighted.
